// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth signed multiplier, one partial-product step per clock.
// Optional MULT_SIGN_MAG_EN adds an sm_mode input for legacy sign-magnitude operands.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one Booth step per cycle, W steps in total
// DONE  | one-cycle done pulse; a new start is accepted here too

module booth_seq_multiplier #(
    parameter int W  = 8,
    parameter int CW = $clog2(W) + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
`ifdef MULT_SIGN_MAG_EN
    input  logic           sm_mode,
`endif
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [W:0]     m_r;
    logic [W:0]     acc_r;
    logic [W-1:0]   q_r;
    logic           q_1_r;
    logic [CW-1:0]  cnt_r;

    logic           load;
    logic           last_step;
    logic [W:0]     m_ld;
    logic [W-1:0]   q_ld;
    logic [W:0]     sum;
    logic [W:0]     acc_sh;
    logic [W-1:0]   q_sh;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] p_nx;

`ifdef MULT_SIGN_MAG_EN
    logic           sm_r;
    logic           sign_r;
    logic           sign_ld;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        load      = 1'b0;
        last_step = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_CALC;
                    load     = 1'b1;
                end
            end
            S_CALC: begin
                if (cnt_r == CW'(W - 1)) begin
                    state_nx  = S_DONE;
                    last_step = 1'b1;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_nx = S_CALC;
                    load     = 1'b1;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy = (state == S_CALC);
    assign done = (state == S_DONE);

    // Sign-magnitude operands become non-negative two's complement, so the
    // same Booth sequence yields the magnitude product.
`ifdef MULT_SIGN_MAG_EN
    assign m_ld    = sm_mode ? {2'b00, a[W-2:0]} : {a[W-1], a};
    assign q_ld    = sm_mode ? {1'b0, b[W-2:0]} : b;
    assign sign_ld = sm_mode & (a[W-1] ^ b[W-1]);
`else
    assign m_ld = {a[W-1], a};
    assign q_ld = b;
`endif

    always_comb begin
        sum = acc_r;
        case ({q_r[0], q_1_r})
            2'b01:   sum = acc_r + m_r;
            2'b10:   sum = acc_r - m_r;
            default: sum = acc_r;
        endcase
    end

    assign acc_sh = {sum[W], sum[W:1]};
    assign q_sh   = {sum[0], q_r[W-1:1]};
    assign prod   = {acc_sh[W-1:0], q_sh};

`ifdef MULT_SIGN_MAG_EN
    // The sign bit is forced even for a zero magnitude (legacy negative zero).
    assign p_nx = sm_r ? {sign_r, prod[2*W-2:0]} : prod;
`else
    assign p_nx = prod;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            m_r    <= '0;
            acc_r  <= '0;
            q_r    <= '0;
            q_1_r  <= 1'b0;
            cnt_r  <= '0;
            p      <= '0;
`ifdef MULT_SIGN_MAG_EN
            sm_r   <= 1'b0;
            sign_r <= 1'b0;
`endif
        end else if (load) begin
            m_r    <= m_ld;
            acc_r  <= '0;
            q_r    <= q_ld;
            q_1_r  <= 1'b0;
            cnt_r  <= '0;
`ifdef MULT_SIGN_MAG_EN
            sm_r   <= sm_mode;
            sign_r <= sign_ld;
`endif
        end else if (busy) begin
            acc_r <= acc_sh;
            q_r   <= q_sh;
            q_1_r <= q_r[0];
            cnt_r <= cnt_r + CW'(1);
            if (last_step) begin
                p <= p_nx;
            end
        end
    end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Scoreboard bench for booth_seq_multiplier: W=8 directed, W=16 random, W=5 sign-magnitude
// (the last only when MULT_SIGN_MAG_EN is defined).

module tb_booth_seq_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        s16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] p16;
`ifdef MULT_SIGN_MAG_EN
    logic        s5, sm5, busy5, done5;
    logic [4:0]  a5, b5;
    logic [9:0]  p5;
`endif

    booth_seq_multiplier #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8),
`ifdef MULT_SIGN_MAG_EN
        .sm_mode(1'b0),
`endif
        .a(a8), .b(b8), .busy(busy8), .done(done8), .p(p8)
    );

    booth_seq_multiplier #(.W(16)) dut16 (
        .clk(clk), .rst(rst), .start(s16),
`ifdef MULT_SIGN_MAG_EN
        .sm_mode(1'b0),
`endif
        .a(a16), .b(b16), .busy(busy16), .done(done16), .p(p16)
    );

`ifdef MULT_SIGN_MAG_EN
    booth_seq_multiplier #(.W(5)) dut5 (
        .clk(clk), .rst(rst), .start(s5), .sm_mode(sm5),
        .a(a5), .b(b5), .busy(busy5), .done(done5), .p(p5)
    );
`endif

    typedef struct {
        logic [31:0] p;
        int          due;
    } exp_t;

    exp_t        q8[$];
    exp_t        q16[$];
    exp_t        e8, e16;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;
    int          run8 = 0, run16 = 0;
    logic [15:0] last_p8 = '0;
    logic [31:0] last_p16 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // done must land W+1 cycles after the accepting edge, with exactly W busy cycles before it
    always @(negedge clk) begin
        if (busy8) begin
            run8++;
            check("p8_hold", p8, last_p8);
        end
        if (done8) begin
            if (q8.size() == 0) begin
                check("done8_extra", 1, 0);
            end else begin
                e8 = q8.pop_front();
                check("p8", p8, e8.p[15:0]);
                check("lat8", cyc, e8.due);
                check("busy8_len", run8, 8);
                last_p8 = e8.p[15:0];
            end
            run8 = 0;
        end
    end

    always @(negedge clk) begin
        if (busy16) begin
            run16++;
            check("p16_hold", p16, last_p16);
        end
        if (done16) begin
            if (q16.size() == 0) begin
                check("done16_extra", 1, 0);
            end else begin
                e16 = q16.pop_front();
                check("p16", p16, e16.p);
                check("lat16", cyc, e16.due);
                check("busy16_len", run16, 16);
                last_p16 = e16.p;
            end
            run16 = 0;
        end
    end

    task automatic mul8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] expp);
        int n = 0;
        while (busy8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy8) check("wait8", busy8, 0);
        s8 = 1'b1;
        a8 = a;
        b8 = b;
        q8.push_back('{p: {16'h0, expp}, due: cyc + 1 + 8});
        @(negedge clk);
        s8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
    endtask

    task automatic mul16(input logic [15:0] a, input logic [15:0] b, input logic [31:0] expp);
        int n = 0;
        while (busy16 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (busy16) check("wait16", busy16, 0);
        s16 = 1'b1;
        a16 = a;
        b16 = b;
        q16.push_back('{p: expp, due: cyc + 1 + 16});
        @(negedge clk);
        s16 = 1'b0;
        a16 = 16'($urandom);
        b16 = 16'($urandom);
    endtask

    task automatic drain8();
        int n = 0;
        while ((q8.size() != 0 || busy8 || done8) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain8", q8.size(), 0);
    endtask

    task automatic drain16();
        int n = 0;
        while ((q16.size() != 0 || busy16 || done16) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain16", q16.size(), 0);
    endtask

`ifdef MULT_SIGN_MAG_EN
    task automatic sm_run(input logic [4:0] a, input logic [4:0] b, input logic [9:0] expp);
        int n = 0;
        int due;
        s5  = 1'b1;
        sm5 = 1'b1;
        a5  = a;
        b5  = b;
        due = cyc + 1 + 5;
        @(negedge clk);
        s5 = 1'b0;
        while (!done5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("p5", p5, expp);
        check("lat5", cyc, due);
        @(negedge clk);
    endtask
`endif

    initial begin
        logic [7:0]  ra8, rb8;
        logic [15:0] ra16, rb16;
        logic [15:0] m8;
        logic [31:0] m16;
        int          n;

        rst = 1'b1;
        s8 = 1'b0; a8 = '0; b8 = '0;
        s16 = 1'b0; a16 = '0; b16 = '0;
`ifdef MULT_SIGN_MAG_EN
        s5 = 1'b0; sm5 = 1'b0; a5 = '0; b5 = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_p8", p8, 0);
        check("rst_p16", p16, 0);
        rst = 1'b0;
        @(negedge clk);

        // directed W=8 cases with known products
        mul8(8'd7, 8'hFD, 16'hFFEB);
        drain8();
        mul8(8'h80, 8'h80, 16'h4000);
        mul8(8'h80, 8'h7F, 16'hC080);
        mul8(8'h00, 8'h5A, 16'h0000);
        mul8(8'h7F, 8'h7F, 16'h3F01);
        mul8(8'hFF, 8'h80, 16'h0080);
        drain8();

        // start in DONE: accepted without an IDLE cycle; start pulses during CALC ignored
        mul8(8'd5, 8'd6, 16'd30);
        n = 0;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done8_seen", done8, 1);
        mul8(8'd3, 8'd4, 16'd12);
        repeat (3) begin
            s8 = 1'b1;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            @(negedge clk);
            s8 = 1'b0;
            @(negedge clk);
        end
        drain8();

        // reset mid-calculation aborts the job
        mul8(8'h11, 8'h22, 16'h0242);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q8.delete();
        run8 = 0;
        last_p8 = '0;
        check("abort_busy8", busy8, 0);
        check("abort_done8", done8, 0);
        check("abort_p8", p8, 0);
        repeat (12) @(negedge clk);
        mul8(8'hFF, 8'hFF, 16'h0001);
        drain8();

        for (int i = 0; i < 20; i++) begin
            ra8 = 8'($urandom);
            rb8 = 8'($urandom);
            m8  = 16'($signed({{8{ra8[7]}}, ra8}) * $signed({{8{rb8[7]}}, rb8}));
            mul8(ra8, rb8, m8);
        end
        drain8();

        for (int i = 0; i < 1000; i++) begin
            ra16 = 16'($urandom);
            rb16 = 16'($urandom);
            if (i == 0) begin ra16 = 16'h8000; rb16 = 16'h8000; end
            if (i == 1) begin ra16 = 16'h8000; rb16 = 16'h7FFF; end
            m16 = 32'($signed({{16{ra16[15]}}, ra16}) * $signed({{16{rb16[15]}}, rb16}));
            mul16(ra16, rb16, m16);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(negedge clk);
        end
        drain16();

`ifdef MULT_SIGN_MAG_EN
        sm_run(5'b10011, 5'b00101, 10'b1000001111);
        sm_run(5'b10000, 5'b00011, 10'b1000000000);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/booth_seq_multiplier.md
Name: booth_seq_multiplier

Overview:
- Parametrised sequential signed multiplier. Radix-2 Booth recoding, one partial-product step per clock.
- Generalises the team's fixed 5-bit combinational sign-magnitude multiplier:
  - arbitrary operand width W
  - two's-complement operands
  - start/busy/done handshake
- Sits between a control FSM or switch/button front end and display/ALU logic. Used where a wide combinational array would not meet timing or area on the Spartan-3E.

Parameters:
- W, default 8: operand width in bits. Legal range 2..32. Product is 2W bits.
- CW, default $clog2(W)+1: step-counter width. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  W  multiplicand, two's complement (sign-magnitude when the optional feature is enabled and sm_mode=1)
- b  input  W  multiplier, same format as a
- busy  output  1  high while in CALC
- done  output  1  one-cycle pulse; p is valid from this cycle onward
- p  output  2W  product, registered, held until the next accepted start

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, busy=0, done=0, p=0, all internal registers 0. Reset in the middle of an operation aborts it; no done pulse is produced for the aborted job.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1: latch a into M (sign-extended to W+1 bits). Load accumulator A=0, Q=b, q_1=0, cnt=0. Next state CALC, busy=1.
  - start=0: stay in IDLE.
- CALC, one Booth step per cycle, decided by {Q[0], q_1}:
  - 01: A=A+M
  - 10: A=A-M
  - 00 or 11: no operation
  - Then arithmetic-shift {A,Q,q_1} right by one, and cnt=cnt+1.
  - A is W+1 bits, so M=-2^(W-1) and subtraction never overflow.
  - After the W-th step (cnt==W-1 at the edge): next state DONE. p={A[W-1:0],Q} of the final shifted value. busy=0.
- DONE:
  - done=1 for exactly this cycle.
  - start=1 in DONE: new operands accepted with the same action as IDLE; next state CALC.
  - Otherwise next state IDLE.
- Latency:
  - start sampled at edge N; busy=1 for cycles N+1..N+W; done=1 in cycle N+W+1.
  - Throughput is one product per W+1 cycles with back-to-back starts.
- start while busy=1 is ignored, and a, b are not re-sampled during CALC. The caller may change a and b freely after the accepting edge.
- p changes only at the CALC→DONE transition or on reset. The previous product stays visible during a new CALC.
- Boundary products (W=8):
  - -128*-128 = +16384 (0x4000)
  - -128*127 = -16256 (0xC080)
  - 0*x = 0
  - No overflow is possible in 2W bits.

Optional Feature:
- Macro: MULT_SIGN_MAG_EN
- Defined:
  - Adds input port sm_mode (1 bit), sampled with start.
  - sm_mode=1, input side: a and b are sign-magnitude (bit W-1 = sign, W-2:0 = magnitude). The magnitudes are multiplied as unsigned, zero-extended, using the same CALC sequence.
  - sm_mode=1, output side: p[2W-1] = a[W-1]^b[W-1], always, even when the magnitude is zero. This is legacy-compatible "negative zero". p[2W-2:0] = magnitude product, zero-extended.
  - sm_mode=0: two's-complement behaviour as above.
  - Latency is identical in both modes.
- Not defined: no sm_mode port; two's complement only.

Test Plan:
- W=8; reset, then a=7, b=-3 (0xFD), start 1 cycle → busy for 8 cycles, done pulse in cycle 9, p=0xFFEB (-21).
- W=8; a=0x80, b=0x80 → p=0x4000. Then a=0x80, b=0x7F → p=0xC080. a=0, b=0x5A → p=0x0000.
- W=8; start asserted in DONE with a=3, b=4 → no IDLE cycle, busy next cycle, p=12 after 9 cycles. start pulses during CALC are ignored, with no extra done.
- W=8; rst=1 at CALC step 4 → next cycle busy=0, done=0, p=0. A subsequent start with a=-1, b=-1 gives p=1.
- W=16; randomised 1000 operand pairs compared to a signed reference model. Check done exactly W+1 cycles after each accepting edge.
- MULT_SIGN_MAG_EN, W=5, sm_mode=1: a=5'b10011, b=5'b00101 → p=10'b1000001111 (-15). a=5'b10000, b=5'b00011 → p=10'b1000000000.
